pack_s_reader: RTL

// Reads the secret vector s = (s1 || s2) back out of the coefficient RAM that ExpandS writes,
// via the RAM's second (read-only) port. Each signed coefficient c is mapped to (ETA - c) and
// bit-packed LSB-first into a 64-bit output stream, producing the s1/s2 field of the secret key
// (FIPS 204 BitPack). Sits between the vector_s RAM and the sk serializer.

---
 rtl/pack_s_reader.sv | 140 ++++++++++++++
 1 files changed

// File: rtl/pack_s_reader.sv
// Streams s1||s2 out of the coefficient RAM as (ETA - c) bit-packed LSB-first 64-bit beats.
// Optional range checking of absorbed coefficients is built when PACK_S_RANGE_CHECK_EN is defined.
module pack_s_reader #(
    parameter int K           = 8,
    parameter int L           = 7,
    parameter int N           = 256,
    parameter int ETA         = 2,
    parameter int WORD_LEN    = 96,
    parameter int COEFF_WIDTH = 24,
    parameter int OUT_BITS    = 64,
    parameter int ADDR_WIDTH  = $clog2((L + K) * N * COEFF_WIDTH / WORD_LEN)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    output logic                  busy,
    output logic                  done,
    output logic [ADDR_WIDTH-1:0] addr_s,
    output logic                  re_s,
    input  logic [WORD_LEN-1:0]   dout_s,
    output logic [OUT_BITS-1:0]   out_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic                  out_last,
    output logic                  err_range
);
    localparam int CPW   = WORD_LEN / COEFF_WIDTH;
    localparam int BW    = (ETA == 2) ? 3 : 4;
    localparam int WB    = CPW * BW;
    localparam int WORDS = (L + K) * N / CPW;
    localparam int ACC_W = 2 * OUT_BITS;
    localparam int FW    = $clog2(ACC_W + 1);

    localparam logic [FW-1:0]         OB_F    = FW'(OUT_BITS);
    localparam logic [FW-1:0]         WB_F    = FW'(WB);
    localparam logic [FW:0]           WB_N    = (FW + 1)'(WB);
    localparam logic [FW:0]           WB2_N   = (FW + 1)'(2 * WB);
    localparam logic [FW:0]           ACC_N   = (FW + 1)'(ACC_W);
    localparam logic [ADDR_WIDTH:0]   WORDS_C = (ADDR_WIDTH + 1)'(WORDS);
    localparam logic [BW-1:0]         ETA_B   = BW'(ETA);

    typedef enum logic [1:0] {IDLE, RUN, FIN} state_t;

    state_t                state, state_nx;
    logic [ADDR_WIDTH:0]   rd_cnt;
    logic                  pending;
    logic [ACC_W-1:0]      acc, acc_shift, acc_nx;
    logic [FW-1:0]         fill, fill_shift, fill_nx;
    logic [FW:0]           need;
    logic [WB-1:0]         word_packed;
    logic                  words_done, accept, issue, launch;

    // Map each slot to ETA - c; only the low BW bits of the difference are kept.
    for (genvar j = 0; j < CPW; j++) begin : g_slot
        logic [BW-1:0] mapped;
        assign mapped = ETA_B - dout_s[j*COEFF_WIDTH +: BW];
        assign word_packed[j*BW +: BW] = mapped;
    end

    always_comb begin
        launch     = (state == IDLE) && start;
        words_done = (rd_cnt == WORDS_C) && !pending;
        out_valid  = (state == RUN) && ((fill >= OB_F) || (words_done && (fill != '0)));
        out_last   = out_valid && words_done && (fill <= OB_F);
        out_data   = acc[OUT_BITS-1:0];
        accept     = out_valid && out_ready;
        // Space check reserves room for the word still in flight.
        need       = {1'b0, fill} + (pending ? WB2_N : WB_N);
        issue      = (state == RUN) && (rd_cnt != WORDS_C) && (need <= ACC_N);
        re_s       = issue;
        addr_s     = rd_cnt[ADDR_WIDTH-1:0];
        busy       = (state != IDLE);
        done       = (state == FIN);

        acc_shift  = accept ? (acc >> OUT_BITS) : acc;
        fill_shift = fill;
        if (accept) fill_shift = (fill >= OB_F) ? (fill - OB_F) : '0;
        acc_nx  = acc_shift;
        fill_nx = fill_shift;
        if (pending) begin
            acc_nx  = acc_shift | (ACC_W'(word_packed) << fill_shift);
            fill_nx = fill_shift + WB_F;
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (start) state_nx = RUN;
            RUN:     if (accept && out_last) state_nx = FIN;
            FIN:     state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            rd_cnt  <= '0;
            pending <= 1'b0;
            acc     <= '0;
            fill    <= '0;
        end else begin
            state <= state_nx;
            if (launch) begin
                rd_cnt  <= '0;
                pending <= 1'b0;
                acc     <= '0;
                fill    <= '0;
            end else begin
                pending <= issue;
                if (issue) rd_cnt <= rd_cnt + 1'b1;
                acc  <= acc_nx;
                fill <= fill_nx;
            end
        end
    end

`ifdef PACK_S_RANGE_CHECK_EN
    localparam logic signed [COEFF_WIDTH-1:0] ETA_POS = COEFF_WIDTH'(ETA);
    localparam logic signed [COEFF_WIDTH-1:0] ETA_NEG = COEFF_WIDTH'(-ETA);

    logic [CPW-1:0] slot_bad;
    for (genvar j = 0; j < CPW; j++) begin : g_range
        logic signed [COEFF_WIDTH-1:0] c;
        assign c           = dout_s[j*COEFF_WIDTH +: COEFF_WIDTH];
        assign slot_bad[j] = (c > ETA_POS) || (c < ETA_NEG);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)                          err_range <= 1'b0;
        else if (launch)                  err_range <= 1'b0;
        else if (pending && |slot_bad)    err_range <= 1'b1;
    end
`else
    logic unused_hi;
    assign unused_hi = ^dout_s;
    assign err_range = 1'b0;
`endif
endmodule
